// File: rtl/sr_status_ctrl_pkg.sv
// Shared definitions for the status-register controller: SR bit map, flag-write
// lane order, jump condition codes and the low-power/interrupt controller states.
package sr_status_ctrl_pkg;

  localparam int SR_C      = 0;
  localparam int SR_Z      = 1;
  localparam int SR_N      = 2;
  localparam int SR_GIE    = 3;
  localparam int SR_CPUOFF = 4;
  localparam int SR_OSCOFF = 5;
  localparam int SR_SCG0   = 6;
  localparam int SR_SCG1   = 7;
  localparam int SR_V      = 8;

  localparam logic [15:0] SR_IMPL_MASK = 16'h01FF;

  // Lane order of flag_we / flag_in, packed as {V,N,Z,C}
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [2:0] {
    JC_JNE = 3'd0,
    JC_JEQ = 3'd1,
    JC_JNC = 3'd2,
    JC_JC  = 3'd3,
    JC_JN  = 3'd4,
    JC_JGE = 3'd5,
    JC_JL  = 3'd6,
    JC_JMP = 3'd7
  } jcond_e;

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_SLEEP     = 2'd1,
    ST_WAKE      = 2'd2,
    ST_IRQ_ENTRY = 2'd3
  } sr_state_e;

  function automatic logic signedLess(input logic n, input logic v);
    return n ^ v;
  endfunction

endpackage

// File: rtl/sr_jcond_eval.sv
// Combinational decoder of the eight MSP430 jump conditions from the SR flags.
module sr_jcond_eval
  import sr_status_ctrl_pkg::*;
(
  input  logic [2:0] i_jcond,
  input  logic       i_c,
  input  logic       i_z,
  input  logic       i_n,
  input  logic       i_v,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    unique case (jcond_e'(i_jcond))
      JC_JNE: o_taken = ~i_z;
      JC_JEQ: o_taken = i_z;
      JC_JNC: o_taken = ~i_c;
      JC_JC:  o_taken = i_c;
      JC_JN:  o_taken = i_n;
      JC_JGE: o_taken = ~signedLess(i_n, i_v);
      JC_JL:  o_taken = signedLess(i_n, i_v);
      JC_JMP: o_taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/sr_status_ctrl.sv
// Status register owner: SR writes, jump-condition output and the CPUOFF sleep /
// wake / interrupt-entry sequencer. Define SR_JCOND_REG_EN to register jump_taken.
module sr_status_ctrl
  import sr_status_ctrl_pkg::*;
#(
  parameter int SR_W     = 16,
  parameter int WAKE_DLY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      i_flag_we,
  input  logic [3:0]      i_flag_in,
  input  logic            i_sr_we,
  input  logic [SR_W-1:0] i_sr_wdata,
  input  logic            i_reti_valid,
  input  logic [SR_W-1:0] i_reti_sr,
  input  logic            i_irq_req,
  input  logic [2:0]      i_jcond,
  output logic [SR_W-1:0] o_sr_out,
  output logic            o_jump_taken,
  output logic            o_cpu_stall,
  output logic            o_irq_take,
  output logic [SR_W-1:0] o_sr_saved
);

  localparam int               CNT_W         = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;
  localparam logic [CNT_W-1:0] WAKE_LAST     = CNT_W'(WAKE_DLY - 1);
  localparam logic [SR_W-1:0]  IMPL_MASK     = SR_W'(SR_IMPL_MASK);
  localparam logic [SR_W-1:0]  IRQ_KEEP_MASK = SR_W'(1) << SR_SCG0;

  sr_state_e        r_state;
  sr_state_e        w_stateNext;
  logic [SR_W-1:0]  r_sr;
  logic [SR_W-1:0]  w_srNext;
  logic [CNT_W-1:0] r_wakeCnt;
  logic [CNT_W-1:0] w_wakeCntNext;
  logic             w_irqAccept;
  logic             w_taken;

  assign w_irqAccept = i_irq_req & r_sr[SR_GIE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_ACTIVE;
      r_sr      <= '0;
      r_wakeCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_sr      <= w_srNext;
      r_wakeCnt <= w_wakeCntNext;
    end
  end

  // Only a running core writes SR; interrupt entry clears everything except SCG0
  always_comb begin
    w_srNext = r_sr;
    unique case (r_state)
      ST_ACTIVE: begin
        if (i_reti_valid) begin
          w_srNext = i_reti_sr & IMPL_MASK;
        end else if (i_sr_we) begin
          w_srNext = i_sr_wdata & IMPL_MASK;
        end else begin
          if (i_flag_we[FLAG_C]) w_srNext[SR_C] = i_flag_in[FLAG_C];
          if (i_flag_we[FLAG_Z]) w_srNext[SR_Z] = i_flag_in[FLAG_Z];
          if (i_flag_we[FLAG_N]) w_srNext[SR_N] = i_flag_in[FLAG_N];
          if (i_flag_we[FLAG_V]) w_srNext[SR_V] = i_flag_in[FLAG_V];
        end
      end
      ST_IRQ_ENTRY: w_srNext = r_sr & IRQ_KEEP_MASK;
      default: w_srNext = r_sr;
    endcase
  end

  // Pending interrupts beat CPUOFF; both decisions look at the registered SR
  always_comb begin
    w_stateNext   = r_state;
    w_wakeCntNext = r_wakeCnt;
    o_cpu_stall   = 1'b1;
    o_irq_take    = 1'b0;
    o_sr_saved    = '0;
    unique case (r_state)
      ST_ACTIVE: begin
        o_cpu_stall = 1'b0;
        if (w_irqAccept) begin
          w_stateNext = ST_IRQ_ENTRY;
        end else if (r_sr[SR_CPUOFF]) begin
          w_stateNext = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (w_irqAccept) begin
          w_stateNext   = ST_WAKE;
          w_wakeCntNext = '0;
        end
      end
      ST_WAKE: begin
        if (r_wakeCnt == WAKE_LAST) begin
          w_stateNext = ST_IRQ_ENTRY;
        end else begin
          w_wakeCntNext = r_wakeCnt + CNT_W'(1);
        end
      end
      ST_IRQ_ENTRY: begin
        o_irq_take  = 1'b1;
        o_sr_saved  = r_sr;
        w_stateNext = ST_ACTIVE;
      end
    endcase
  end

  assign o_sr_out = r_sr;

  sr_jcond_eval u_jcond (
    .i_jcond (i_jcond),
    .i_c     (r_sr[SR_C]),
    .i_z     (r_sr[SR_Z]),
    .i_n     (r_sr[SR_N]),
    .i_v     (r_sr[SR_V]),
    .o_taken (w_taken)
  );

`ifdef SR_JCOND_REG_EN
  logic r_jumpTaken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jumpTaken <= 1'b0;
    end else begin
      r_jumpTaken <= w_taken;
    end
  end

  assign o_jump_taken = r_jumpTaken;
`else
  assign o_jump_taken = w_taken;
`endif

endmodule

// File: tb/tb_sr_status_ctrl.sv
// Self-checking bench for sr_status_ctrl: directed scenarios pinned with literal
// values, then randomized traffic compared every cycle against a behavioural model.
module tb_sr_status_ctrl;

  localparam int WAKE_DLY = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  flagWe;
  logic [3:0]  flagIn;
  logic        srWe;
  logic [15:0] srWdata;
  logic        retiValid;
  logic [15:0] retiSr;
  logic        irqReq;
  logic [2:0]  jcond;
  logic [15:0] srOut;
  logic        jumpTaken;
  logic        cpuStall;
  logic        irqTake;
  logic [15:0] srSaved;

  always #5 clk = ~clk;

  sr_status_ctrl #(.SR_W(16), .WAKE_DLY(WAKE_DLY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flag_we    (flagWe),
    .i_flag_in    (flagIn),
    .i_sr_we      (srWe),
    .i_sr_wdata   (srWdata),
    .i_reti_valid (retiValid),
    .i_reti_sr    (retiSr),
    .i_irq_req    (irqReq),
    .i_jcond      (jcond),
    .o_sr_out     (srOut),
    .o_jump_taken (jumpTaken),
    .o_cpu_stall  (cpuStall),
    .o_irq_take   (irqTake),
    .o_sr_saved   (srSaved)
  );

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: what the core is doing, the SR value and remaining wake cycles
  typedef enum {M_RUN, M_SLEEP, M_WAKE, M_ENTRY} mode_t;
  mode_t       mMode;
  logic [15:0] mSr;
  int          wakeLeft;
  logic        mJumpPrev;
  int          flagPos [4] = '{0, 1, 2, 8};

  function automatic logic jumpRule(input logic [2:0] cond, input logic [15:0] s);
    logic c, z, n, v;
    c = s[0]; z = s[1]; n = s[2]; v = s[8];
    case (cond)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !c;
      3'd3:    return c;
      3'd4:    return n;
      3'd5:    return n == v;
      3'd6:    return n != v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic void compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic modelReset();
    mMode     = M_RUN;
    mSr       = 16'h0000;
    wakeLeft  = 0;
    mJumpPrev = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic modelStep();
    logic [15:0] nSr;
    logic        accept;
    if (!rst_n) begin
      modelReset();
      return;
    end
    mJumpPrev = jumpRule(jcond, mSr);
    accept    = irqReq && mSr[3];
    case (mMode)
      M_RUN: begin
        if (retiValid)  nSr = retiSr & 16'h01FF;
        else if (srWe)  nSr = srWdata & 16'h01FF;
        else begin
          nSr = mSr;
          for (int i = 0; i < 4; i++)
            if (flagWe[i]) nSr[flagPos[i]] = flagIn[i];
        end
        if (accept)      mMode = M_ENTRY;
        else if (mSr[4]) mMode = M_SLEEP;
        mSr = nSr;
      end
      M_SLEEP: begin
        if (accept) begin
          mMode    = M_WAKE;
          wakeLeft = WAKE_DLY;
        end
      end
      M_WAKE: begin
        wakeLeft--;
        if (wakeLeft == 0) mMode = M_ENTRY;
      end
      M_ENTRY: begin
        mSr   = mSr & 16'h0040;
        mMode = M_RUN;
      end
    endcase
  endtask

  // Drive all inputs just after a falling edge; an asserted reset acts at once
  task automatic applyStimulus(input logic rn, input logic [3:0] fwe, input logic [3:0] fin,
                               input logic swe, input logic [15:0] swd, input logic rv,
                               input logic [15:0] rsr, input logic irq, input logic [2:0] jc);
    rst_n     = rn;
    flagWe    = fwe;
    flagIn    = fin;
    srWe      = swe;
    srWdata   = swd;
    retiValid = rv;
    retiSr    = rsr;
    irqReq    = irq;
    jcond     = jc;
    if (!rn) modelReset();
  endtask

  task automatic idle(input logic irq, input logic [2:0] jc);
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, irq, jc);
  endtask

  // Compare every output with the model, step the model, move to the next falling edge
  task automatic checkOutput();
    logic expJump;
    #1;
`ifdef SR_JCOND_REG_EN
    expJump = mJumpPrev;
`else
    expJump = jumpRule(jcond, mSr);
`endif
    compare("sr_out",     srOut,     mSr);
    compare("cpu_stall",  {15'd0, cpuStall},  {15'd0, mMode != M_RUN});
    compare("irq_take",   {15'd0, irqTake},   {15'd0, mMode == M_ENTRY});
    compare("sr_saved",   srSaved,   (mMode == M_ENTRY) ? mSr : 16'h0000);
    compare("jump_taken", {15'd0, jumpTaken}, {15'd0, expJump});
    modelStep();
    @(negedge clk);
  endtask

  // Hold a condition code for two cycles, then pin the jump result to a literal
  task automatic holdJump(input logic [2:0] jc, input logic exp, input string name);
    idle(1'b0, jc);
    checkOutput();
    idle(1'b0, jc);
    #1 compare(name, {15'd0, jumpTaken}, {15'd0, exp});
    checkOutput();
  endtask

  initial begin
    modelReset();
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd3);
    @(negedge clk);
    @(negedge clk);
    #1;
    compare("reset sr_out",     srOut, 16'h0000);
    compare("reset cpu_stall",  {15'd0, cpuStall}, 16'h0000);
    compare("reset irq_take",   {15'd0, irqTake}, 16'h0000);
    compare("reset sr_saved",   srSaved, 16'h0000);
    compare("reset jump_taken", {15'd0, jumpTaken}, 16'h0000);
    checkOutput();

    // Flag write of C and Z
    applyStimulus(1'b1, 4'b0011, 4'b0011, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd1);
    checkOutput();
    holdJump(3'd1, 1'b1, "JEQ with Z=1");
    #1 compare("flag write sr_out", srOut, 16'h0003);
    checkOutput();
    holdJump(3'd0, 1'b0, "JNE with Z=1");

    // RETI beats a simultaneous full write; upper bits forced to zero
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1, 16'hFFFF, 1'b1, 16'h0104, 1'b0, 3'd7);
    checkOutput();
    idle(1'b0, 3'd7);
    #1 compare("RETI priority sr_out", srOut, 16'h0104);
    checkOutput();

    // Signed conditions
    applyStimulus(1'b1, 4'b1000, 4'b0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd5);
    checkOutput();
    holdJump(3'd5, 1'b0, "JGE N=1 V=0");
    holdJump(3'd6, 1'b1, "JL N=1 V=0");
    applyStimulus(1'b1, 4'b1000, 4'b1000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd5);
    checkOutput();
    holdJump(3'd5, 1'b1, "JGE N=1 V=1");
    holdJump(3'd7, 1'b1, "JMP");

    // GIE|CPUOFF: sleep, wake on irq, interrupt entry
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b1, 16'h0018, 1'b0, 16'h0000, 1'b0, 3'd7);
    checkOutput();
    idle(1'b0, 3'd7);
    #1 compare("stall before sleep", {15'd0, cpuStall}, 16'h0000);
    checkOutput();
    idle(1'b0, 3'd7);
    #1 compare("sleep stall", {15'd0, cpuStall}, 16'h0001);
    checkOutput();
    idle(1'b1, 3'd7);
    checkOutput();
    for (int i = 0; i < WAKE_DLY; i++) begin
      idle(1'b0, 3'd7);
      #1 compare("wake stall", {15'd0, cpuStall}, 16'h0001);
      compare("wake no take", {15'd0, irqTake}, 16'h0000);
      checkOutput();
    end
    idle(1'b0, 3'd7);
    #1 compare("entry irq_take", {15'd0, irqTake}, 16'h0001);
    compare("entry sr_saved", srSaved, 16'h0018);
    checkOutput();
    idle(1'b0, 3'd7);
    #1 compare("after entry sr_out", srOut, 16'h0000);
    compare("after entry stall", {15'd0, cpuStall}, 16'h0000);
    checkOutput();

    // CPUOFF with GIE=0: irq cannot wake it
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b1, 16'h0050, 1'b0, 16'h0000, 1'b1, 3'd7);
    checkOutput();
    idle(1'b1, 3'd7);
    checkOutput();
    for (int i = 0; i < 20; i++) begin
      idle(1'b1, 3'd7);
      #1 compare("stuck sleep stall", {15'd0, cpuStall}, 16'h0001);
      compare("stuck sleep no take", {15'd0, irqTake}, 16'h0000);
      checkOutput();
    end
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 3'd3);
    #1 compare("async reset sr_out", srOut, 16'h0000);
    compare("async reset stall", {15'd0, cpuStall}, 16'h0000);
    compare("async reset jump", {15'd0, jumpTaken}, 16'h0000);
    checkOutput();

    // Irq beats a simultaneous CPUOFF write; RETI with CPUOFF re-enters sleep
    idle(1'b0, 3'd7);
    checkOutput();
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b1, 16'h0008, 1'b0, 16'h0000, 1'b0, 3'd7);
    checkOutput();
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b1, 16'h0018, 1'b0, 16'h0000, 1'b1, 3'd7);
    checkOutput();
    idle(1'b0, 3'd7);
    #1 compare("irq over cpuoff take", {15'd0, irqTake}, 16'h0001);
    compare("irq over cpuoff saved", srSaved, 16'h0018);
    checkOutput();
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b1, 16'h0018, 1'b0, 3'd7);
    checkOutput();
    idle(1'b0, 3'd7);
    #1 compare("RETI cpuoff not yet asleep", {15'd0, cpuStall}, 16'h0000);
    checkOutput();
    idle(1'b0, 3'd7);
    #1 compare("RETI cpuoff asleep", {15'd0, cpuStall}, 16'h0001);
    checkOutput();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic        rn;
      logic [15:0] wd;
      rn = (n < 2) ? 1'b0 : ($urandom_range(0, 149) != 0);
      wd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) wd[4] = 1'b0;
      applyStimulus(rn,
                    ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0,
                    4'($urandom),
                    ($urandom_range(0, 9) == 0),
                    wd,
                    ($urandom_range(0, 19) == 0),
                    16'($urandom),
                    ($urandom_range(0, 3) == 0),
                    3'($urandom));
      checkOutput();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
